// File: rtl/fifo_demo_pkg.sv
// rtl/fifo_demo_pkg.sv - shared state encodings and defaults for the asymmetric FIFO demo
package fifo_demo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_HALT  = 2'd3
    } chk_state_t;

    localparam logic [15:0] DEFAULT_SEED = 16'h0001;

endpackage

// File: rtl/fifo_pattern_gen.sv
// rtl/fifo_pattern_gen.sv - incrementing counter pattern generator (load/advance/resync)
//  rd_clk, sys_rst_n : clock, asynchronous active-low reset
//  load              : reload the counter with SEED
//  advance           : step the counter by two half-words
//  resync            : reload from resync_half + 2
//  exp_word          : current pair of half-words, earlier one placed per LSB_FIRST
module fifo_pattern_gen
    import fifo_demo_pkg::*;
#(
    parameter int                    HALF_WIDTH = 16,
    parameter logic [HALF_WIDTH-1:0] SEED       = HALF_WIDTH'(DEFAULT_SEED),
    parameter bit                    LSB_FIRST  = 1'b1
) (
    input  logic                    rd_clk,
    input  logic                    sys_rst_n,
    input  logic                    load,
    input  logic                    advance,
    input  logic                    resync,
    input  logic [HALF_WIDTH-1:0]   resync_half,
    output logic [2*HALF_WIDTH-1:0] exp_word
);

    logic [HALF_WIDTH-1:0] exp_q;
    logic [HALF_WIDTH-1:0] exp_p1;

    // Arithmetic wraps modulo 2^HALF_WIDTH, so the pair {0x0000, 0xFFFF} is legal.
    assign exp_p1   = exp_q + HALF_WIDTH'(1);
    assign exp_word = LSB_FIRST ? {exp_p1, exp_q} : {exp_q, exp_p1};

    always_ff @(posedge rd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            exp_q <= SEED;
        end else if (load) begin
            exp_q <= SEED;
        end else if (resync) begin
            exp_q <= resync_half + HALF_WIDTH'(2);
        end else if (advance) begin
            exp_q <= exp_q + HALF_WIDTH'(2);
        end
    end

endmodule

// File: rtl/fifo_stream_checker.sv
// rtl/fifo_stream_checker.sv - read-side pattern checker for the 1:2 asymmetric FIFO demo
//  Inputs : rd_clk, sys_rst_n, start_i, stop_i, fifo_rst_busy_i, fifo_empty_i,
//           fifo_trigger_i, fifo_rdata_i, fifo_rd_valid_i
//  Outputs: fifo_rd_en_o (registered), error_o, proto_err_o (sticky),
//           err_count_o (saturating), word_count_o (wrapping),
//           first_exp_o/first_act_o (first mismatch), state_o
module fifo_stream_checker
    import fifo_demo_pkg::*;
#(
    parameter int                    HALF_WIDTH    = 16,
    parameter logic [HALF_WIDTH-1:0] SEED          = HALF_WIDTH'(DEFAULT_SEED),
    parameter bit                    LSB_FIRST     = 1'b1,
    parameter bit                    RESYNC        = 1'b1,
    parameter bit                    STOP_ON_ERROR = 1'b0,
    parameter int                    MAX_OUTSTAND  = 4,
    parameter int                    ERR_CNT_W     = 16
) (
    input  logic                    rd_clk,
    input  logic                    sys_rst_n,
    input  logic                    start_i,
    input  logic                    stop_i,
    input  logic                    fifo_rst_busy_i,
    input  logic                    fifo_empty_i,
    input  logic                    fifo_trigger_i,
    output logic                    fifo_rd_en_o,
    input  logic [2*HALF_WIDTH-1:0] fifo_rdata_i,
    input  logic                    fifo_rd_valid_i,
    output logic                    error_o,
    output logic                    proto_err_o,
    output logic [ERR_CNT_W-1:0]    err_count_o,
    output logic [31:0]             word_count_o,
    output logic [2*HALF_WIDTH-1:0] first_exp_o,
    output logic [2*HALF_WIDTH-1:0] first_act_o,
    output logic [1:0]              state_o
);

    localparam int DW    = 2 * HALF_WIDTH;
    localparam int OUT_W = $clog2(MAX_OUTSTAND + 1);

    chk_state_t            state_q;
    logic [OUT_W-1:0]      outstanding_q;
    logic [DW-1:0]         exp_word;
    logic [HALF_WIDTH-1:0] earlier_half;
    logic                  accept;
    logic                  mismatch;
    logic                  proto_now;
    logic                  flush;
    logic                  err_now;

    assign accept       = fifo_rd_en_o && !fifo_empty_i;
    assign mismatch     = fifo_rd_valid_i && (fifo_rdata_i != exp_word);
    // A valid with nothing in flight, or one read too many beyond the window.
    assign proto_now    = (fifo_rd_valid_i && (outstanding_q == '0) && !accept) ||
                          (accept && !fifo_rd_valid_i && (outstanding_q == OUT_W'(MAX_OUTSTAND)));
    // A FIFO reset mid-run restarts the stream; HALT ignores it so the failure stays visible.
    assign flush        = fifo_rst_busy_i && (state_q != ST_HALT);
    assign err_now      = mismatch || proto_now;
    assign earlier_half = LSB_FIRST ? fifo_rdata_i[HALF_WIDTH-1:0] : fifo_rdata_i[DW-1:HALF_WIDTH];
    assign state_o      = state_q;

    fifo_pattern_gen #(
        .HALF_WIDTH (HALF_WIDTH),
        .SEED       (SEED),
        .LSB_FIRST  (LSB_FIRST)
    ) u_pattern_gen (
        .rd_clk      (rd_clk),
        .sys_rst_n   (sys_rst_n),
        .load        (flush),
        .advance     (fifo_rd_valid_i),
        .resync      (RESYNC && mismatch),
        .resync_half (earlier_half),
        .exp_word    (exp_word)
    );

    // Read enable is dropped in the same edge that leaves RUN so no extra read is issued.
    always_ff @(posedge rd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= ST_IDLE;
            fifo_rd_en_o <= 1'b0;
        end else begin
            fifo_rd_en_o <= 1'b0;
            if (flush) begin
                state_q <= ST_IDLE;
            end else begin
                case (state_q)
                    ST_IDLE:  if (start_i) state_q <= ST_ARMED;
                    ST_ARMED: if (fifo_trigger_i) state_q <= ST_RUN;
                    ST_RUN: begin
                        if (STOP_ON_ERROR && err_now) begin
                            state_q <= ST_HALT;
                        end else begin
                            fifo_rd_en_o <= !stop_i && !fifo_empty_i &&
                                            (outstanding_q < OUT_W'(MAX_OUTSTAND));
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge rd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            outstanding_q <= '0;
        end else if (flush) begin
            outstanding_q <= '0;
        end else if (accept && !fifo_rd_valid_i) begin
            if (outstanding_q != OUT_W'(MAX_OUTSTAND)) outstanding_q <= outstanding_q + OUT_W'(1);
        end else if (!accept && fifo_rd_valid_i && (outstanding_q != '0)) begin
            outstanding_q <= outstanding_q - OUT_W'(1);
        end
    end

    always_ff @(posedge rd_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            error_o      <= 1'b0;
            proto_err_o  <= 1'b0;
            err_count_o  <= '0;
            word_count_o <= '0;
            first_exp_o  <= '0;
            first_act_o  <= '0;
        end else begin
            if (proto_now) proto_err_o <= 1'b1;
            if (fifo_rd_valid_i) begin
                word_count_o <= word_count_o + 32'd1;
                if (mismatch) begin
                    error_o <= 1'b1;
                    if (err_count_o != '1) err_count_o <= err_count_o + ERR_CNT_W'(1);
                    if (!error_o) begin
                        first_exp_o <= exp_word;
                        first_act_o <= fifo_rdata_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_stream_checker.sv
// tb/tb_fifo_stream_checker.sv - directed bench for fifo_stream_checker
module tb_fifo_stream_checker;

    logic        rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Instance 0: defaults; 1: SEED=0xFFFD; 2: STOP_ON_ERROR=1
    logic        rst_n [3];
    logic        start [3];
    logic        stop  [3];
    logic        busy  [3];
    logic        trig  [3];
    logic        empty [3];
    logic        rd_en [3];
    logic        vld   [3] = '{1'b0, 1'b0, 1'b0};
    logic [31:0] rdata [3] = '{32'd0, 32'd0, 32'd0};
    logic        err   [3];
    logic        proto [3];
    logic [15:0] ecnt  [3];
    logic [31:0] wc    [3];
    logic [31:0] fexp  [3];
    logic [31:0] fact  [3];
    logic [1:0]  st    [3];

    logic        gate  [3];
    logic        inj   [3];
    logic        flush [3];
    logic [31:0] inj_data;
    logic [31:0] mem   [3][0:2047];
    int          wr_ptr[3];
    int          rd_ptr[3] = '{0, 0, 0};

    int          n_chk  = 0;
    int          n_fail = 0;
    int          wc0;
    logic        any_rd;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fifo_stream_checker #(
            .SEED          (g == 1 ? 16'hFFFD : 16'h0001),
            .STOP_ON_ERROR (g == 2)
        ) u_dut (
            .rd_clk          (rd_clk),
            .sys_rst_n       (rst_n[g]),
            .start_i         (start[g]),
            .stop_i          (stop[g]),
            .fifo_rst_busy_i (busy[g]),
            .fifo_empty_i    (empty[g]),
            .fifo_trigger_i  (trig[g]),
            .fifo_rd_en_o    (rd_en[g]),
            .fifo_rdata_i    (rdata[g]),
            .fifo_rd_valid_i (vld[g]),
            .error_o         (err[g]),
            .proto_err_o     (proto[g]),
            .err_count_o     (ecnt[g]),
            .word_count_o    (wc[g]),
            .first_exp_o     (fexp[g]),
            .first_act_o     (fact[g]),
            .state_o         (st[g])
        );
    end

    always_comb begin
        for (int i = 0; i < 3; i++) empty[i] = (rd_ptr[i] == wr_ptr[i]) || gate[i];
    end

    // FIFO read side: one-cycle read latency, plus injected stray valids.
    always @(posedge rd_clk) begin
        for (int i = 0; i < 3; i++) begin
            vld[i] <= 1'b0;
            if (flush[i]) begin
                rd_ptr[i] <= wr_ptr[i];
            end else if (rd_en[i] && !empty[i]) begin
                vld[i]    <= 1'b1;
                rdata[i]  <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end else if (inj[i]) begin
                vld[i]   <= 1'b1;
                rdata[i] <= inj_data;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [31:0] w);
        mem[i][wr_ptr[i]] = w;
        wr_ptr[i]++;
    endtask

    task automatic push_pat(input int i, input logic [15:0] lo, input int n);
        logic [15:0] v;
        v = lo;
        for (int k = 0; k < n; k++) begin
            push(i, {v + 16'd1, v});
            v = v + 16'd2;
        end
    endtask

    task automatic wait_wc(input int i, input int target, input string tag);
        int c;
        c = 0;
        while (int'(wc[i]) < target && c < 4000) begin
            @(negedge rd_clk);
            c++;
        end
        chk(tag, wc[i], target);
    endtask

    task automatic reset_dut(input int i);
        rst_n[i] = 1'b0;
        flush[i] = 1'b1;
        @(negedge rd_clk);
        rst_n[i] = 1'b1;
        flush[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0; start[i] = 1'b0; stop[i] = 1'b0; busy[i] = 1'b0;
            trig[i]  = 1'b0; gate[i]  = 1'b0; inj[i]  = 1'b0; flush[i] = 1'b0;
            wr_ptr[i] = 0;
        end
        inj_data = 32'd0;
        repeat (3) @(negedge rd_clk);

        chk("rst_state", 32'(st[0]), 0);
        chk("rst_rd_en", 32'(rd_en[0]), 0);
        chk("rst_error", 32'(err[0]), 0);
        chk("rst_proto", 32'(proto[0]), 0);
        chk("rst_wc", wc[0], 0);
        chk("rst_ecnt", 32'(ecnt[0]), 0);
        chk("rst_fexp", fexp[0], 0);
        chk("rst_fact", fact[0], 0);
        for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

        // 1. clean drain of 1000 words
        push_pat(0, 16'h0001, 1000);
        start[0] = 1'b1;
        @(negedge rd_clk);
        chk("t1_armed", 32'(st[0]), 1);
        chk("t1_no_rd_armed", 32'(rd_en[0]), 0);
        trig[0] = 1'b1;
        @(negedge rd_clk);
        chk("t1_run", 32'(st[0]), 2);
        wait_wc(0, 1000, "t1_wc");
        chk("t1_error", 32'(err[0]), 0);
        chk("t1_proto", 32'(proto[0]), 0);
        chk("t1_ecnt", 32'(ecnt[0]), 0);

        // 2a. word 5 fully corrupt: resync from 0xBEEF makes word 6 fail too
        reset_dut(0);
        push_pat(0, 16'h0001, 4);
        push(0, 32'hDEAD_BEEF);
        push_pat(0, 16'h000B, 5);
        wait_wc(0, 10, "t2a_wc");
        chk("t2a_ecnt", 32'(ecnt[0]), 2);
        chk("t2a_error", 32'(err[0]), 1);
        chk("t2a_fexp", fexp[0], 32'h000A_0009);
        chk("t2a_fact", fact[0], 32'hDEAD_BEEF);
        chk("t2a_proto", 32'(proto[0]), 0);

        // 2b. earlier half intact: only one error
        reset_dut(0);
        push_pat(0, 16'h0001, 4);
        push(0, 32'h0000_0009);
        push_pat(0, 16'h000B, 5);
        wait_wc(0, 10, "t2b_wc");
        chk("t2b_ecnt", 32'(ecnt[0]), 1);
        chk("t2b_fexp", fexp[0], 32'h000A_0009);
        chk("t2b_fact", fact[0], 32'h0000_0009);

        // 4. stray valid with nothing outstanding
        start[0] = 1'b0;
        reset_dut(0);
        inj_data = 32'h0002_0001;
        inj[0] = 1'b1;
        @(negedge rd_clk);
        inj[0] = 1'b0;
        chk("t4_proto_before", 32'(proto[0]), 0);
        @(negedge rd_clk);
        chk("t4_proto", 32'(proto[0]), 1);
        chk("t4_error", 32'(err[0]), 0);
        chk("t4_wc", wc[0], 1);

        // 5. FIFO reset mid-run, then restart from SEED
        reset_dut(0);
        start[0] = 1'b1;
        push_pat(0, 16'h0001, 200);
        repeat (60) @(negedge rd_clk);
        chk("t5_running", 32'(st[0]), 2);
        busy[0] = 1'b1; gate[0] = 1'b1; flush[0] = 1'b1;
        @(negedge rd_clk);
        flush[0] = 1'b0;
        chk("t5_idle", 32'(st[0]), 0);
        chk("t5_rd_en", 32'(rd_en[0]), 0);
        repeat (7) @(negedge rd_clk);
        chk("t5_hold_idle", 32'(st[0]), 0);
        wc0 = int'(wc[0]);
        busy[0] = 1'b0; gate[0] = 1'b0;
        push_pat(0, 16'h0001, 20);
        wait_wc(0, wc0 + 20, "t5_wc");
        chk("t5_ecnt", 32'(ecnt[0]), 0);
        chk("t5_error", 32'(err[0]), 0);
        chk("t5_proto", 32'(proto[0]), 0);

        // 3. counter wrap at 0xFFFF
        push(1, 32'hFFFE_FFFD);
        push(1, 32'h0000_FFFF);
        push(1, 32'h0002_0001);
        start[1] = 1'b1; trig[1] = 1'b1;
        wait_wc(1, 3, "t3_wc");
        chk("t3_error", 32'(err[1]), 0);
        chk("t3_ecnt", 32'(ecnt[1]), 0);

        // 6. stop_i gating, then halt on first error
        push_pat(2, 16'h0001, 10);
        stop[2] = 1'b1; start[2] = 1'b1; trig[2] = 1'b1;
        any_rd = 1'b0;
        repeat (20) begin
            @(negedge rd_clk);
            any_rd = any_rd | rd_en[2];
        end
        chk("t6_stop_state", 32'(st[2]), 2);
        chk("t6_stop_rd", 32'(any_rd), 0);
        chk("t6_stop_wc", wc[2], 0);
        stop[2] = 1'b0;
        wait_wc(2, 10, "t6_wc");
        chk("t6_clean_error", 32'(err[2]), 0);
        push(2, 32'h1234_5678);
        wait_wc(2, 11, "t6_bad_wc");
        chk("t6_halt", 32'(st[2]), 3);
        chk("t6_error", 32'(err[2]), 1);
        chk("t6_fexp", fexp[2], 32'h0016_0015);
        push_pat(2, 16'h0017, 4);
        any_rd = 1'b0;
        repeat (12) begin
            gate[2] = ~gate[2];
            @(negedge rd_clk);
            any_rd = any_rd | rd_en[2];
        end
        chk("t6_halt_rd", 32'(any_rd), 0);
        chk("t6_halt_wc", wc[2], 11);
        chk("t6_halt_state", 32'(st[2]), 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
